// File: rtl/mult_wb_tracker_pkg.sv
// rtl/mult_wb_tracker_pkg.sv - shared widths, write-back select codes and grant type
package mult_wb_tracker_pkg;

    localparam int REG_ADDR = 5;

    localparam logic WB_SEL_ALU  = 1'b0;
    localparam logic WB_SEL_MULT = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MULT = 2'd2
    } grant_e;

endpackage

// File: rtl/mult_wb_tracker_stage_reg.sv
// rtl/mult_wb_tracker_stage_reg.sv - one {dst, regwrite} multiplier shadow stage with enable
module mult_stage_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] dst_d,
    input  logic         regwrite_d,
    output logic [W-1:0] dst_q,
    output logic         regwrite_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q      <= '0;
            regwrite_q <= 1'b0;
        end else if (en_i) begin
            dst_q      <= dst_d;
            regwrite_q <= regwrite_d;
        end
    end

endmodule

// File: rtl/mult_wb_tracker.sv
// rtl/mult_wb_tracker.sv - multiplier M1..M5 metadata shadow and register-file write-port arbiter
module mult_wb_tracker
    import mult_wb_tracker_pkg::*;
#(
    parameter int REG_ADDR     = mult_wb_tracker_pkg::REG_ADDR,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [REG_ADDR-1:0] issue_dst,
    input  logic                issue_regwrite,
    output logic                issue_ready,
    output logic [REG_ADDR-1:0] m1_dst_reg,
    output logic [REG_ADDR-1:0] m2_dst_reg,
    output logic [REG_ADDR-1:0] m3_dst_reg,
    output logic [REG_ADDR-1:0] m4_dst_reg,
    output logic [REG_ADDR-1:0] m5_dst_reg,
    output logic                m1_regwrite,
    output logic                m2_regwrite,
    output logic                m3_regwrite,
    output logic                m4_regwrite,
    output logic                m5_regwrite,
    input  logic                alu_wb_valid,
    input  logic [REG_ADDR-1:0] alu_wb_dst,
    output logic                alu_wb_stall,
    output logic                mult_hold,
    output logic                wb_we,
    output logic [REG_ADDR-1:0] wb_dst,
    output logic                wb_sel
);

    localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

    // Index 0 is the issue slot feeding M1; indices 1..5 are the stage registers.
    logic [REG_ADDR-1:0] stage_dst [0:5];
    logic                stage_rw  [0:5];

    logic [1:0] starve_cnt_q, starve_cnt_d;
    logic       mreq, areq;
    grant_e     grant;

    assign stage_dst[0] = issue_dst;
    assign stage_rw[0]  = issue_valid & issue_regwrite & (issue_dst != '0);

    for (genvar k = 1; k <= 5; k++) begin : g_stage
        mult_stage_reg #(
            .W (REG_ADDR)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (~mult_hold),
            .dst_d      (stage_dst[k-1]),
            .regwrite_d (stage_rw[k-1]),
            .dst_q      (stage_dst[k]),
            .regwrite_q (stage_rw[k])
        );
    end

    assign m1_dst_reg  = stage_dst[1];
    assign m2_dst_reg  = stage_dst[2];
    assign m3_dst_reg  = stage_dst[3];
    assign m4_dst_reg  = stage_dst[4];
    assign m5_dst_reg  = stage_dst[5];
    assign m1_regwrite = stage_rw[1];
    assign m2_regwrite = stage_rw[2];
    assign m3_regwrite = stage_rw[3];
    assign m4_regwrite = stage_rw[4];
    assign m5_regwrite = stage_rw[5];

    assign mreq = stage_rw[5];
    assign areq = alu_wb_valid & (alu_wb_dst != '0);

    // The counter only advances on a lost contention, so it saturates at STARVE_MAX.
    always_comb begin
        grant        = GNT_NONE;
        alu_wb_stall = 1'b0;
        mult_hold    = 1'b0;
        starve_cnt_d = '0;
        if (mreq && areq) begin
            if (starve_cnt_q == STARVE_MAX) begin
                grant     = GNT_ALU;
                mult_hold = 1'b1;
            end else begin
                grant        = GNT_MULT;
                alu_wb_stall = 1'b1;
                starve_cnt_d = starve_cnt_q + 2'd1;
            end
        end else if (mreq) begin
            grant = GNT_MULT;
        end else if (areq) begin
            grant = GNT_ALU;
        end
    end

    always_comb begin
        wb_we  = 1'b0;
        wb_sel = WB_SEL_ALU;
        wb_dst = '0;
        case (grant)
            GNT_MULT: begin
                wb_we  = 1'b1;
                wb_sel = WB_SEL_MULT;
                wb_dst = stage_dst[5];
            end
            GNT_ALU: begin
                wb_we  = 1'b1;
                wb_sel = WB_SEL_ALU;
                wb_dst = alu_wb_dst;
            end
            default: ;
        endcase
    end

    assign issue_ready = ~mult_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt_q <= '0;
        else        starve_cnt_q <= starve_cnt_d;
    end

endmodule

// File: tb/tb_mult_wb_tracker.sv
// tb/tb_mult_wb_tracker.sv - directed and random checks of mult_wb_tracker against a reference model
module tb_mult_wb_tracker;

    localparam int RA    = 5;
    localparam int LIMIT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid, issue_regwrite;
    logic [RA-1:0] issue_dst;
    logic          issue_ready;
    logic [RA-1:0] m1_dst_reg, m2_dst_reg, m3_dst_reg, m4_dst_reg, m5_dst_reg;
    logic          m1_regwrite, m2_regwrite, m3_regwrite, m4_regwrite, m5_regwrite;
    logic          alu_wb_valid;
    logic [RA-1:0] alu_wb_dst;
    logic          alu_wb_stall, mult_hold, wb_we, wb_sel;
    logic [RA-1:0] wb_dst;

    int total = 0;
    int bad   = 0;

    // Reference model: the five in-flight ops as plain arrays plus a loss count.
    int r_dst [1:5];
    bit r_rw  [1:5];
    int r_cnt;
    bit e_we, e_sel, e_stall, e_hold;
    int e_dst;

    always #5 clk = ~clk;

    mult_wb_tracker #(.REG_ADDR(RA), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_regwrite(issue_regwrite),
        .issue_ready(issue_ready),
        .m1_dst_reg(m1_dst_reg), .m2_dst_reg(m2_dst_reg), .m3_dst_reg(m3_dst_reg),
        .m4_dst_reg(m4_dst_reg), .m5_dst_reg(m5_dst_reg),
        .m1_regwrite(m1_regwrite), .m2_regwrite(m2_regwrite), .m3_regwrite(m3_regwrite),
        .m4_regwrite(m4_regwrite), .m5_regwrite(m5_regwrite),
        .alu_wb_valid(alu_wb_valid), .alu_wb_dst(alu_wb_dst), .alu_wb_stall(alu_wb_stall),
        .mult_hold(mult_hold), .wb_we(wb_we), .wb_dst(wb_dst), .wb_sel(wb_sel)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= 5; k++) begin
            r_dst[k] = 0;
            r_rw[k]  = 0;
        end
        r_cnt = 0;
    endtask

    task automatic model_outputs();
        bit mreq, areq;
        mreq = r_rw[5];
        areq = alu_wb_valid && (alu_wb_dst != 0);
        e_we = 0; e_sel = 0; e_dst = 0; e_stall = 0; e_hold = 0;
        if (mreq && areq && r_cnt < LIMIT) begin
            e_we = 1; e_sel = 1; e_dst = r_dst[5]; e_stall = 1;
        end else if (mreq && areq) begin
            e_we = 1; e_sel = 0; e_dst = alu_wb_dst; e_hold = 1;
        end else if (mreq) begin
            e_we = 1; e_sel = 1; e_dst = r_dst[5];
        end else if (areq) begin
            e_we = 1; e_sel = 0; e_dst = alu_wb_dst;
        end
    endtask

    task automatic compare_all();
        logic [63:0] exp_st, obs_st;
        model_outputs();
        exp_st = '0;
        for (int k = 1; k <= 5; k++) exp_st = (exp_st << 6) | 64'((r_dst[k] << 1) | int'(r_rw[k]));
        obs_st = 64'({m1_dst_reg, m1_regwrite, m2_dst_reg, m2_regwrite, m3_dst_reg, m3_regwrite,
                      m4_dst_reg, m4_regwrite, m5_dst_reg, m5_regwrite});
        check("stages", obs_st, exp_st);
        check("wb", 64'({wb_we, wb_sel, wb_dst}), 64'({e_we, e_sel, RA'(e_dst)}));
        check("hold_stall_ready", 64'({mult_hold, alu_wb_stall, issue_ready}),
              64'({e_hold, e_stall, !e_hold}));
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic advance();
        model_outputs();
        @(posedge clk);
        if (!e_hold) begin
            for (int k = 5; k >= 2; k--) begin
                r_dst[k] = r_dst[k-1];
                r_rw[k]  = r_rw[k-1];
            end
            r_dst[1] = issue_dst;
            r_rw[1]  = issue_valid && issue_regwrite && (issue_dst != 0);
        end
        r_cnt = e_stall ? r_cnt + 1 : 0;
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_regwrite = 0; issue_dst = 0;
        alu_wb_valid = 0; alu_wb_dst = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;
        #2;
        compare_all();
        check("reset_ready", 64'(issue_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1;

        // Single issue: five-edge latency to the write port.
        issue_valid = 1; issue_regwrite = 1; issue_dst = 5;
        step();
        idle_inputs();
        settle();
        check("m1_after_issue", 64'({m1_dst_reg, m1_regwrite}), 64'({5'd5, 1'b1}));
        advance();
        repeat (3) step();
        settle();
        check("m5_write", 64'({wb_we, wb_sel, wb_dst}), 64'({1'b1, 1'b1, 5'd5}));
        advance();
        settle();
        check("empty_after", 64'(wb_we), 64'd0);
        advance();

        // Non-writing issues: dst 0, and regwrite 0.
        issue_valid = 1; issue_regwrite = 1; issue_dst = 0;
        step();
        issue_regwrite = 0; issue_dst = 9;
        step();
        idle_inputs();
        repeat (6) begin
            settle();
            check("no_mult_we", 64'(wb_we), 64'd0);
            advance();
        end

        // Contention: mult dst 7 at M5 vs ALU dst 3.
        issue_valid = 1; issue_regwrite = 1; issue_dst = 7;
        step();
        idle_inputs();
        repeat (4) step();
        alu_wb_valid = 1; alu_wb_dst = 3;
        settle();
        check("contend_mult", 64'({wb_sel, wb_dst, alu_wb_stall}), 64'({1'b1, 5'd7, 1'b1}));
        advance();
        settle();
        check("contend_alu_next", 64'({wb_we, wb_sel, wb_dst, alu_wb_stall}),
              64'({1'b1, 1'b0, 5'd3, 1'b0}));
        advance();
        idle_inputs();
        step();

        // Starvation: back-to-back mults against a continuous ALU request.
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1; issue_regwrite = 1; issue_dst = RA'(10 + i);
            step();
        end
        alu_wb_valid = 1; alu_wb_dst = 3;
        issue_dst = 15;
        settle();
        check("starve_stall1", 64'(alu_wb_stall), 64'd1);
        advance();
        issue_dst = 16;
        settle();
        check("starve_stall2", 64'(alu_wb_stall), 64'd1);
        advance();
        issue_dst = 17;
        settle();
        check("starve_alu_wins", 64'({mult_hold, issue_ready, wb_sel, wb_dst, m5_dst_reg}),
              64'({1'b1, 1'b0, 1'b0, 5'd3, 5'd12}));
        advance();
        settle();
        check("starve_m5_written", 64'({wb_sel, wb_dst, alu_wb_stall}), 64'({1'b1, 5'd12, 1'b1}));
        advance();
        idle_inputs();
        repeat (6) step();

        // ALU dst 0 during a mult write: dropped, no stall.
        issue_valid = 1; issue_regwrite = 1; issue_dst = 9;
        step();
        idle_inputs();
        repeat (4) step();
        alu_wb_valid = 1; alu_wb_dst = 0;
        settle();
        check("alu_dst0", 64'({wb_we, wb_sel, wb_dst, alu_wb_stall}), 64'({1'b1, 1'b1, 5'd9, 1'b0}));
        advance();
        idle_inputs();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            issue_valid    = ($urandom_range(0, 9) < 7);
            issue_regwrite = ($urandom_range(0, 9) < 8);
            issue_dst      = ($urandom_range(0, 7) == 0) ? RA'(0) : RA'($urandom_range(1, 31));
            alu_wb_valid   = ($urandom_range(0, 9) < 6);
            alu_wb_dst     = ($urandom_range(0, 7) == 0) ? RA'(0) : RA'($urandom_range(1, 31));
            step();
        end
        idle_inputs();

        // Asynchronous reset with three mults in flight.
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_regwrite = 1; issue_dst = RA'(20 + i);
            step();
        end
        idle_inputs();
        step();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check("async_rst_rw", 64'({m1_regwrite, m2_regwrite, m3_regwrite, m4_regwrite, m5_regwrite}), 64'd0);
        check("async_rst_we", 64'(wb_we), 64'd0);
        @(posedge clk); #3;
        rst_n = 1;
        repeat (8) begin
            settle();
            check("post_rst_we", 64'(wb_we), 64'd0);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
